// File: rtl/mem_dma.sv
// mem_dma: word-granular memory-to-memory DMA engine with a register target port.
// Define MEM_DMA_FILL_EN to add the FILL register and the constant-fill mode.
module mem_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [4:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    output logic        irq,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_WR_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [4:0] A_SRC  = 5'h00;
    localparam logic [4:0] A_DST  = 5'h04;
    localparam logic [4:0] A_LEN  = 5'h08;
    localparam logic [4:0] A_CTRL = 5'h0C;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_ready;
    logic [31:0]            r_data_o;
    logic [31:0]            r_src;
    logic [31:0]            r_dst;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_done;
    logic                   r_irq_en;
    logic                   r_m_valid;
    logic [31:0]            r_m_addr;
    logic [31:0]            r_m_wdata;
    logic [3:0]             r_m_wstrb;

    logic                   w_wr;
    logic                   w_busy;
    logic                   w_start;
    logic                   w_go;
    logic                   w_wr_ack;
    logic                   w_fill_mode;
    logic                   w_start_fill;
    logic [31:0]            w_fill_word;
    logic [31:0]            w_rd_data;
    logic                   w_m_valid_next;
    logic [31:0]            w_m_addr_next;
    logic [31:0]            w_m_wdata_next;
    logic [3:0]             w_m_wstrb_next;

    // A register write lands in the cycle ready is high, while the CPU still holds select.
    assign w_wr     = r_ready & select & (wstrb != 4'h0);
    assign w_busy   = (r_state != S_IDLE);
    assign w_start  = w_wr && (addr == A_CTRL) && data_i[0] && !w_busy;
    assign w_go     = w_start && (r_len != '0);
    assign w_wr_ack = (r_state == S_WR_REQ) && m_ready;

`ifdef MEM_DMA_FILL_EN
    localparam logic [4:0] A_FILL = 5'h10;
    logic        r_mode_fill;
    logic [31:0] r_fill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_fill <= 1'b0;
            r_fill      <= 32'h0;
        end else begin
            if (w_wr && (addr == A_FILL)) r_fill <= data_i;
            if (w_wr && (addr == A_CTRL) && !w_busy) r_mode_fill <= data_i[4];
        end
    end

    assign w_fill_mode  = r_mode_fill;
    assign w_start_fill = data_i[4];
    assign w_fill_word  = r_fill;
`else
    assign w_fill_mode  = 1'b0;
    assign w_start_fill = 1'b0;
    assign w_fill_word  = 32'h0;
`endif

    always_comb begin
        w_rd_data = 32'h0;
        case (addr)
            A_SRC:   w_rd_data = r_src;
            A_DST:   w_rd_data = r_dst;
            A_LEN:   w_rd_data = 32'(r_len);
            A_CTRL:  w_rd_data = {27'd0, w_fill_mode, r_irq_en, r_done, w_busy, 1'b0};
`ifdef MEM_DMA_FILL_EN
            A_FILL:  w_rd_data = r_fill;
`endif
            default: w_rd_data = 32'h0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_go) w_state_next = w_start_fill ? S_WR_REQ : S_RD_REQ;
            S_RD_REQ: if (m_ready) w_state_next = S_WR_GAP;
            S_WR_GAP: w_state_next = S_WR_REQ;
            S_WR_REQ: begin
                if (m_ready) begin
                    if (r_len == LEN_ONE)  w_state_next = S_DONE;
                    else if (w_fill_mode)  w_state_next = S_WR_GAP;
                    else                   w_state_next = S_RD_GAP;
                end
            end
            S_RD_GAP: w_state_next = S_RD_REQ;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase

        // Initiator outputs load only on entry to a request state, so they hold while waiting.
        w_m_valid_next = (w_state_next == S_RD_REQ) || (w_state_next == S_WR_REQ);
        w_m_addr_next  = r_m_addr;
        w_m_wstrb_next = r_m_wstrb;
        w_m_wdata_next = r_m_wdata;
        if (w_state_next != r_state) begin
            if (w_state_next == S_RD_REQ) begin
                w_m_addr_next  = r_src;
                w_m_wstrb_next = 4'h0;
            end
            if (w_state_next == S_WR_REQ) begin
                w_m_addr_next  = r_dst;
                w_m_wstrb_next = 4'hf;
            end
        end
        if ((r_state == S_IDLE) && (w_state_next == S_WR_REQ)) w_m_wdata_next = w_fill_word;
        if ((r_state == S_RD_REQ) && m_ready)                  w_m_wdata_next = m_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
            r_m_addr  <= 32'h0;
            r_m_wdata <= 32'h0;
            r_m_wstrb <= 4'h0;
        end else begin
            r_state   <= w_state_next;
            r_m_valid <= w_m_valid_next;
            r_m_addr  <= w_m_addr_next;
            r_m_wdata <= w_m_wdata_next;
            r_m_wstrb <= w_m_wstrb_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready  <= 1'b0;
            r_data_o <= 32'h0;
            r_src    <= 32'h0;
            r_dst    <= 32'h0;
            r_len    <= '0;
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            r_ready <= select & ~r_ready;
            if (select && !r_ready) r_data_o <= w_rd_data;

            if (w_wr && !w_busy) begin
                if (addr == A_SRC) r_src <= {data_i[31:2], 2'b00};
                if (addr == A_DST) r_dst <= {data_i[31:2], 2'b00};
                if (addr == A_LEN) r_len <= data_i[LEN_WIDTH-1:0];
            end
            if (w_wr && (addr == A_CTRL)) begin
                r_irq_en <= data_i[3];
                if (data_i[2]) r_done <= 1'b0;
            end
            // An empty transfer completes immediately; any other start clears DONE.
            if (w_start) r_done <= (r_len == '0);

            if (w_wr_ack) begin
                if (!w_fill_mode) r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
                r_len <= r_len - LEN_ONE;
            end
            if (r_state == S_DONE) r_done <= 1'b1;
        end
    end

    assign ready   = r_ready;
    assign data_o  = r_data_o;
    assign irq     = r_done & r_irq_en;
    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: register table, directed transfers and random copies
// checked against a cycle/beat model built from the transfer rules.
module tb_mem_dma;

    localparam int LW = 16;
`ifdef MEM_DMA_FILL_EN
    localparam bit FILL_BUILD = 1'b1;
`else
    localparam bit FILL_BUILD = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        select  = 1'b0;
    logic [3:0]  wstrb   = 4'h0;
    logic [4:0]  addr    = 5'h0;
    logic [31:0] data_i  = 32'h0;
    logic        ready;
    logic [31:0] data_o;
    logic        irq;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    mem_dma #(.LEN_WIDTH(LW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .select  (select),
        .wstrb   (wstrb),
        .addr    (addr),
        .data_i  (data_i),
        .ready   (ready),
        .data_o  (data_o),
        .irq     (irq),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [4:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          t_commit = 0;
    int          wait_states = 0;
    logic [31:0] src_mem [logic [31:0]];

    // Written only by the bus-target/monitor process below.
    beat_t       beats[$];
    int          valid_cycles = 0;
    int          irq_rises = 0;
    int          irq_rise_cyc = -1;
    int          unstable_beats = 0;
    bit          irq_prev = 1'b0;
    bit          in_beat = 1'b0;
    bit          h_bad = 1'b0;
    int          wcnt = 0;
    int          b_start = 0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (src_mem.exists(a)) return src_mem[a];
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Target with a programmable number of wait states per beat; also logs irq edges.
    always @(negedge clk) begin
        beat_t b;
        m_ready = 1'b0;
        if (irq && !irq_prev) begin
            irq_rises++;
            irq_rise_cyc = cyc;
        end
        irq_prev = irq;
        if (!reset_n || !m_valid) begin
            in_beat = 1'b0;
            wcnt    = 0;
        end else begin
            valid_cycles++;
            if (!in_beat) begin
                in_beat = 1'b1;
                wcnt    = 0;
                b_start = cyc;
                h_addr  = m_addr;
                h_wdata = m_wdata;
                h_wstrb = m_wstrb;
                h_bad   = 1'b0;
            end else if (m_addr !== h_addr || m_wstrb !== h_wstrb ||
                         (h_wstrb != 4'h0 && m_wdata !== h_wdata)) begin
                h_bad = 1'b1;
            end
            if (wcnt == wait_states) begin
                m_ready = 1'b1;
                b.we  = (m_wstrb == 4'hf);
                b.a   = m_addr;
                b.cyc = b_start;
                if (b.we) b.d = m_wdata;
                else begin
                    m_rdata = mem_rd(m_addr);
                    b.d = m_rdata;
                end
                beats.push_back(b);
                if (h_bad) unstable_beats++;
                in_beat = 1'b0;
                wcnt    = 0;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic reg_rw(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] q);
        int k;
        @(posedge clk); #1;
        select = 1'b1; addr = a; wstrb = s; data_i = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 10);
        chk($sformatf("reg_ready@%h", a), {31'd0, ready}, 32'd1);
        t_commit = cyc;
        q = data_o;
        @(posedge clk); #1;
        select = 1'b0; wstrb = 4'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Program and run one transfer, then compare beats, timing and final registers with the model.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input int w,
                            input bit fill, input logic [31:0] fv, input bit meddle);
        logic [31:0] q;
        logic [31:0] vals[$];
        beat_t       b;
        int          nb0, rises0, unst0, t, per, k, base;
        wait_states = w;
        for (int i = 0; i < n; i++) begin
            vals.push_back(fill ? fv : $urandom);
            if (!fill) src_mem[s + 32'(4 * i)] = vals[i];
        end
        reg_rw(5'h00, 4'hf, s, q);
        reg_rw(5'h04, 4'hf, d, q);
        reg_rw(5'h08, 4'hf, 32'(n), q);
        if (fill) reg_rw(5'h10, 4'hf, fv, q);
        nb0    = beats.size();
        rises0 = irq_rises;
        unst0  = unstable_beats;
        reg_rw(5'h0C, 4'hf, fill ? 32'h19 : 32'h09, q);
        t = t_commit;
        if (meddle) begin
            reg_rw(5'h0C, 4'h0, 32'h0, q);
            chk("busy_ctrl", q, 32'h0000_000A);
            reg_rw(5'h04, 4'hf, 32'h7777_0000, q);
            reg_rw(5'h0C, 4'hf, 32'h09, q);
        end
        per = fill ? (w + 2) : (2 * w + 4);
        k = 0;
        while (irq_rises == rises0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(irq_rises - rises0), 32'd1);
        chk("done_cycle", 32'(irq_rise_cyc), 32'(t + n * per + 1));
        chk("beat_count", 32'(beats.size() - nb0), 32'(fill ? n : 2 * n));
        if (beats.size() - nb0 == (fill ? n : 2 * n)) begin
            for (int i = 0; i < n; i++) begin
                base = t + 1 + i * per;
                if (!fill) begin
                    b = beats[nb0 + 2 * i];
                    chk($sformatf("rd%0d_we", i), {31'd0, b.we}, 32'd0);
                    chk($sformatf("rd%0d_addr", i), b.a, s + 32'(4 * i));
                    chk($sformatf("rd%0d_cyc", i), 32'(b.cyc), 32'(base));
                    b = beats[nb0 + 2 * i + 1];
                    chk($sformatf("wr%0d_cyc", i), 32'(b.cyc), 32'(base + w + 2));
                end else begin
                    b = beats[nb0 + i];
                    chk($sformatf("wr%0d_cyc", i), 32'(b.cyc), 32'(base));
                end
                chk($sformatf("wr%0d_we", i), {31'd0, b.we}, 32'd1);
                chk($sformatf("wr%0d_addr", i), b.a, d + 32'(4 * i));
                chk($sformatf("wr%0d_data", i), b.d, vals[i]);
            end
        end
        chk("stable_while_waiting", 32'(unstable_beats - unst0), 32'd0);
        reg_rw(5'h08, 4'h0, 32'h0, q); chk("len_end", q, 32'h0);
        reg_rw(5'h00, 4'h0, 32'h0, q); chk("src_end", q, fill ? s : s + 32'(4 * n));
        reg_rw(5'h04, 4'h0, 32'h0, q); chk("dst_end", q, d + 32'(4 * n));
        reg_rw(5'h0C, 4'h0, 32'h0, q); chk("ctrl_end", q, fill ? 32'h1C : 32'h0C);
        $display("xfer src %h dst %h len %0d wait %0d fill %0d started %0d", s, d, n, w, fill, t);
    endtask

    vec_t tbl [0:19];

    initial begin
        logic [31:0] q;
        int          k, vc0, rises0, t;

        tbl[0]  = '{5'h00, 4'h0, 32'h0, 32'h0};
        tbl[1]  = '{5'h04, 4'h0, 32'h0, 32'h0};
        tbl[2]  = '{5'h08, 4'h0, 32'h0, 32'h0};
        tbl[3]  = '{5'h0C, 4'h0, 32'h0, 32'h0};
        tbl[4]  = '{5'h00, 4'hf, 32'h0002_0003, 32'h0};
        tbl[5]  = '{5'h00, 4'h0, 32'h0, 32'h0002_0000};
        tbl[6]  = '{5'h04, 4'h1, 32'h0002_0101, 32'h0};
        tbl[7]  = '{5'h04, 4'h0, 32'h0, 32'h0002_0100};
        tbl[8]  = '{5'h08, 4'hf, 32'hABCD_0004, 32'h0};
        tbl[9]  = '{5'h08, 4'h0, 32'h0, 32'h0000_0004};
        tbl[10] = '{5'h14, 4'hf, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{5'h14, 4'h0, 32'h0, 32'h0};
        tbl[12] = '{5'h10, 4'hf, 32'h1234_5678, 32'h0};
        tbl[13] = '{5'h10, 4'h0, 32'h0, FILL_BUILD ? 32'h1234_5678 : 32'h0};
        tbl[14] = '{5'h0C, 4'hf, 32'h0000_0018, 32'h0};
        tbl[15] = '{5'h0C, 4'h0, 32'h0, FILL_BUILD ? 32'h18 : 32'h08};
        tbl[16] = '{5'h0C, 4'h8, 32'h0000_0000, 32'h0};
        tbl[17] = '{5'h0C, 4'h0, 32'h0, 32'h0};
        tbl[18] = '{5'h02, 4'h0, 32'h0, 32'h0};
        tbl[19] = '{5'h00, 4'h0, 32'h0, 32'h0002_0000};

        do_reset();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_m_wstrb", {28'd0, m_wstrb}, 32'h0);
        chk("rst_data_o", data_o, 32'h0);

        for (int i = 0; i < 20; i++) begin
            reg_rw(tbl[i].a, tbl[i].s, tbl[i].d, q);
            if (tbl[i].s == 4'h0) begin
                chk($sformatf("vec%0d_rd@%h", i, tbl[i].a), q, tbl[i].exp);
                $display("vec %0d read  @%h -> %h", i, tbl[i].a, q);
            end else begin
                $display("vec %0d write @%h <- %h", i, tbl[i].a, tbl[i].d);
            end
        end

        // Zero-wait copy of 4 words, then the same with 3 wait states per beat.
        do_reset();
        run_xfer(32'h0002_0000, 32'h0002_0100, 4, 0, 1'b0, 32'h0, 1'b0);
        run_xfer(32'h0002_0000, 32'h0002_0100, 4, 3, 1'b0, 32'h0, 1'b0);

        // Empty transfer: DONE next cycle, no bus traffic; clearing DONE drops irq.
        reg_rw(5'h08, 4'hf, 32'h0, q);
        reg_rw(5'h0C, 4'hf, 32'h4, q);
        vc0    = valid_cycles;
        rises0 = irq_rises;
        reg_rw(5'h0C, 4'hf, 32'h9, q);
        t = t_commit;
        repeat (4) @(negedge clk);
        chk("len0_no_valid", 32'(valid_cycles - vc0), 32'd0);
        chk("len0_irq_rises", 32'(irq_rises - rises0), 32'd1);
        chk("len0_done_cycle", 32'(irq_rise_cyc), 32'(t + 1));
        chk("len0_irq", {31'd0, irq}, 32'd1);
        reg_rw(5'h0C, 4'hf, 32'hC, q);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        reg_rw(5'h0C, 4'h0, 32'h0, q);
        chk("ctrl_after_clear", q, 32'h8);
        $display("len0 start at %0d, irq rose at %0d", t, irq_rise_cyc);

        // Address wrap with ignored mid-transfer DST write and START.
        run_xfer(32'hFFFF_FFF8, 32'h0003_0000, 3, 2, 1'b0, 32'h0, 1'b1);

        // Reset during a waiting write request.
        reg_rw(5'h00, 4'hf, 32'h0000_5000, q);
        reg_rw(5'h04, 4'hf, 32'h0000_6000, q);
        reg_rw(5'h08, 4'hf, 32'h2, q);
        wait_states = 5;
        reg_rw(5'h0C, 4'hf, 32'h9, q);
        k = 0;
        while (!(m_valid && m_wstrb == 4'hf) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("saw_wr_req", {31'd0, m_valid && m_wstrb == 4'hf}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_mid_m_wstrb", {28'd0, m_wstrb}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reg_rw(5'h00, 4'h0, 32'h0, q); chk("rst_mid_src", q, 32'h0);
        reg_rw(5'h04, 4'h0, 32'h0, q); chk("rst_mid_dst", q, 32'h0);
        reg_rw(5'h08, 4'h0, 32'h0, q); chk("rst_mid_len", q, 32'h0);
        reg_rw(5'h0C, 4'h0, 32'h0, q); chk("rst_mid_ctrl", q, 32'h0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        $display("reset applied during write request");

`ifdef MEM_DMA_FILL_EN
        run_xfer(32'h0000_4440, 32'h0002_0000, 8, 0, 1'b1, 32'hA5A5_A5A5, 1'b0);
`endif

        for (int r = 0; r < 6; r++) begin
            run_xfer(32'h1000_0000 + 32'($urandom_range(0, 255) * 4),
                     32'h2000_0000 + 32'($urandom_range(0, 255) * 4),
                     $urandom_range(1, 6), $urandom_range(0, 3),
                     FILL_BUILD && ($urandom_range(0, 1) == 1), $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
